// File: rtl/comparator_pkg.sv
// Shared types for the ForthSuper comparator path: flag vector layout,
// canonical flag encodings and the sequential comparator's FSM states.
package comparator_pkg;

   typedef struct packed {
      logic eq;
      logic neq;
      logic lt;
      logic lte;
      logic gt;
      logic gte;
   } cmp_flags_t;

   localparam cmp_flags_t CMP_EQ = 6'b100101;
   localparam cmp_flags_t CMP_LT = 6'b011100;
   localparam cmp_flags_t CMP_GT = 6'b010011;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

endpackage

// File: rtl/cmp_slice.sv
// Combinational W-bit slice compare. inv_msb flips both slice MSBs so that the
// top slice of a two's-complement operand orders correctly under unsigned compare.
module cmp_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         inv_msb,
   output logic         lt,
   output logic         gt
);

   logic [W-1:0] xm;
   logic [W-1:0] ym;

   always_comb begin
      xm        = x;
      ym        = y;
      xm[W-1]   = x[W-1] ^ inv_msb;
      ym[W-1]   = y[W-1] ^ inv_msb;
   end

   assign lt = (xm < ym);
   assign gt = (xm > ym);

endmodule

// File: rtl/seq_comparator.sv
// Iterative N-bit magnitude comparator: scans W-bit slices MSB-first and stops
// at the first differing slice. Valid/ready on both sides, one transaction at a time.
module seq_comparator
   import comparator_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sgn,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [5:0]   o
);

   localparam int S  = (W > 0) ? N / W : 1;
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   if ((W < 1) || (W > N) || (N % W != 0)) begin : g_bad_params
      $error("seq_comparator: W must divide N and satisfy 1 <= W <= N");
   end

   cmp_state_t    state, state_nx;
   logic [N-1:0]  a_q, b_q;
   logic          sgn_q;
   logic [IW-1:0] idx, idx_nx;
   cmp_flags_t    o_q, o_nx;
   logic [W-1:0]  xs, ys;
   logic          top, slt, sgt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign o         = o_q;

   // Only one slice comparator: the current slice is muxed in by idx.
   assign xs  = W'(a_q >> (W * int'(idx)));
   assign ys  = W'(b_q >> (W * int'(idx)));
   assign top = (idx == IW'(S - 1));

   cmp_slice #(.W(W)) u_slice (
      .x       (xs),
      .y       (ys),
      .inv_msb (sgn_q & top),
      .lt      (slt),
      .gt      (sgt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= IW'(S - 1);
         o_q   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         o_q   <= o_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      o_nx     = o_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               idx_nx   = IW'(S - 1);
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if (slt || sgt) begin
               o_nx     = slt ? CMP_LT : CMP_GT;
               state_nx = DONE;
            end else if (idx == '0) begin
               o_nx     = CMP_EQ;
               state_nx = DONE;
            end else begin
               idx_nx = idx - IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operands are captured only on the accept edge; later input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         a_q   <= a;
         b_q   <= b;
         sgn_q <= sgn;
      end
   end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Iterative N-bit magnitude comparator for the ForthSuper ALU path.
- Scans operands MSB-first, W bits per cycle, and exits early on the first differing slice.
- Supports unsigned and two's-complement signed modes, selected per transaction.
- Valid/ready handshake on input and output. Produces the same 6-bit {eq,neq,lt,lte,gt,gte} flag vector as the combinational comparator, so it is a drop-in replacement where timing forbids a full-width compare.

Parameters:
- N, 32, operand width in bits.
- W, 8, slice width compared per cycle. N % W == 0 and 1 <= W <= N; elaboration error otherwise.
- S, N/W (derived localparam), slice count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept operands.
- a  in  N  operand A.
- b  in  N  operand B.
- sgn  in  1  1 = signed two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- o  out  6  flags {eq,neq,lt,lte,gt,gte}, MSB = eq.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, out_valid=0, o=6'b000000, slice index=S-1, latched operands=0.
- Reset asserted mid-SCAN or mid-DONE aborts the transaction immediately. The result is discarded, never presented.
- FSM states: IDLE, SCAN, DONE.
- in_ready = (state==IDLE). It is combinational from state and holds no other dependency.
- IDLE:
  - in_valid & in_ready at a rising edge latches a, b and sgn, sets idx=S-1, and moves to SCAN.
  - in_valid low: stay in IDLE.
- SCAN, evaluated once per cycle on slice idx (bits idx*W+W-1 .. idx*W):
  - Unsigned compare of the latched slices. When sgn=1 and idx==S-1, the slice MSB of both operands is inverted before comparing.
  - Slices differ: o = CMP_LT if A slice < B slice, else CMP_GT. Move to DONE.
  - Slices equal and idx==0: o = CMP_EQ. Move to DONE.
  - Slices equal and idx>0: idx decrements. Stay in SCAN.
- Latency: SCAN occupies k cycles, where k = S - j and j is the index of the highest differing slice (k=S when the operands are equal). out_valid rises on the edge that ends the k-th SCAN cycle. Minimum k=1, maximum k=S.
- DONE:
  - out_valid=1; o is held stable until the handshake completes.
  - out_valid & out_ready at an edge moves to IDLE, and out_valid drops the same edge. o keeps its last value (don't-care while out_valid=0).
  - Back-to-back transactions therefore have at least 1 IDLE cycle between them. No overlap of accept and result.
- Input stability: a, b and sgn are sampled only at the accept edge. Later changes on those inputs have no effect on the transaction in flight.
- Flag encoding:
  - CMP_EQ = 6'b100101
  - CMP_LT = 6'b011100
  - CMP_GT = 6'b010011
  - Exactly one of eq/lt/gt is set; neq=~eq, lte=lt|eq, gte=gt|eq.
- W==N degenerates to a single SCAN cycle. W==1 gives a bit-serial compare with S=N cycles worst case.

Decomposition:
- Package comparator_pkg:
  - cmp_flags_t: packed struct {eq,neq,lt,lte,gt,gte}.
  - Localparams CMP_EQ, CMP_LT, CMP_GT.
  - cmp_state_t enum {IDLE,SCAN,DONE}.
- Sub-module cmp_slice #(W): combinational; inputs x, y [W-1:0] and inv_msb; outputs lt, gt.
  - Instantiated once, fed by an idx-selected slice mux.
  - Reusable by the existing full-width comparator.

Test Plan:
1. N=32, W=8, sgn=0, a=0, b=1 -> o=011100 after 4 SCAN cycles; out_valid held while out_ready=0 for 3 cycles; o unchanged throughout.
2. sgn=0, a=32'hFFFF_FFFF, b=0 -> o=010011 after 1 SCAN cycle. Then a=b=32'hFFFF_FFFF -> o=100101 after 4 cycles.
3. sgn=1, a=32'hFFFF_FFFF (-1), b=0 -> o=011100 after 1 cycle. Same operands with sgn=0 -> o=010011.
4. sgn=1, a=32'h8000_0000, b=32'h7FFF_FFFF -> o=011100. Also a=32'hFFFF_FFFE, b=32'hFFFF_FFFF -> o=011100 after 4 cycles.
5. rst_n pulsed low mid-SCAN (cycle 2 of 4) -> out_valid=0 and o=000000 asynchronously; in_ready=1; next transaction (a=5, b=5) -> o=100101.
6. Random sweep, W in {1, 8, 32}, 10k operand pairs, both sgn values -> o matches the reference model; SCAN cycles match k; in_valid during SCAN/DONE is ignored.
